// File: rtl/gravador_musica_if.sv
// Recorder-side bundle: control pulses and key code in, song-RAM write port and status out.
// The recorder uses the master view; the controller/RAM side uses the slave view.
interface gravador_musica_if #(
   parameter int ADDR_W  = 5,
   parameter int NOTA_W  = 4,
   parameter int TEMPO_W = 4
);
   logic               inicia;
   logic               para;
   logic [NOTA_W-1:0]  botoes_encoded;
   logic               metro;
   logic               we;
   logic [ADDR_W-1:0]  addr;
   logic [NOTA_W-1:0]  data_nota;
   logic [TEMPO_W-1:0] data_tempo;
   logic               ocupado;
   logic               pronto;
   logic               cheia;
   logic [2:0]         db_estado;

   modport master (
      input  inicia, para, botoes_encoded, metro,
      output we, addr, data_nota, data_tempo, ocupado, pronto, cheia, db_estado
   );

   modport slave (
      output inicia, para, botoes_encoded, metro,
      input  we, addr, data_nota, data_tempo, ocupado, pronto, cheia, db_estado
   );
endinterface

// File: rtl/gravador_musica.sv
// Records key presses as (note, ticks) words into the song RAM, closing with a zero marker word.
// Registered outputs; a release or stop is written one cycle after it is sampled, no backpressure.
module gravador_musica #(
   parameter int ADDR_W  = 5,
   parameter int NOTA_W  = 4,
   parameter int TEMPO_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   gravador_musica_if.master bus
);
   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] ESPERA  = 3'd1;
   localparam logic [2:0] MEDINDO = 3'd2;
   localparam logic [2:0] GRAVA   = 3'd3;
   localparam logic [2:0] MARCA   = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

   // The last RAM word is kept for the marker, so the final note goes one below it.
   localparam logic [ADDR_W-1:0]  ULTIMO_DADO = {{(ADDR_W-1){1'b1}}, 1'b0};
   localparam logic [TEMPO_W-1:0] TEMPO_MAX   = '1;

   logic [2:0]         estado;
   logic [NOTA_W-1:0]  nota_reg;
   logic [TEMPO_W-1:0] ticks;
   logic               para_visto;
   logic [TEMPO_W-1:0] ticks_final;
   logic [TEMPO_W-1:0] tempo_gravado;
   logic               sai_medindo;

   // A tick landing on the same edge as the release still belongs to the note.
   always_comb begin
      ticks_final = ticks;
      if (bus.metro && (ticks != TEMPO_MAX)) begin
         ticks_final = ticks + TEMPO_W'(1);
      end
      tempo_gravado = (ticks_final == '0) ? TEMPO_W'(1) : ticks_final;
      sai_medindo   = (bus.botoes_encoded != nota_reg) || bus.para || para_visto;
   end

   assign bus.db_estado = estado;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado         <= OCIOSO;
         nota_reg       <= '0;
         ticks          <= '0;
         para_visto     <= 1'b0;
         bus.we         <= 1'b0;
         bus.addr       <= '0;
         bus.data_nota  <= '0;
         bus.data_tempo <= '0;
         bus.ocupado    <= 1'b0;
         bus.pronto     <= 1'b0;
         bus.cheia      <= 1'b0;
      end else begin
         bus.we     <= 1'b0;
         bus.pronto <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.inicia) begin
                  bus.addr    <= '0;
                  bus.cheia   <= 1'b0;
                  bus.ocupado <= 1'b1;
                  para_visto  <= 1'b0;
                  estado      <= ESPERA;
               end
            end
            ESPERA: begin
               if (bus.botoes_encoded != '0) begin
                  nota_reg   <= bus.botoes_encoded;
                  ticks      <= '0;
                  para_visto <= bus.para;
                  estado     <= MEDINDO;
               end else if (bus.para) begin
                  bus.we         <= 1'b1;
                  bus.data_nota  <= '0;
                  bus.data_tempo <= '0;
                  estado         <= MARCA;
               end
            end
            MEDINDO: begin
               ticks <= ticks_final;
               if (bus.para) begin
                  para_visto <= 1'b1;
               end
               if (sai_medindo) begin
                  bus.we         <= 1'b1;
                  bus.data_nota  <= nota_reg;
                  bus.data_tempo <= tempo_gravado;
                  estado         <= GRAVA;
               end
            end
            GRAVA: begin
               bus.addr <= bus.addr + ADDR_W'(1);
               if ((bus.addr == ULTIMO_DADO) || para_visto || bus.para) begin
                  bus.cheia      <= (bus.addr == ULTIMO_DADO);
                  bus.we         <= 1'b1;
                  bus.data_nota  <= '0;
                  bus.data_tempo <= '0;
                  estado         <= MARCA;
               end else if ((bus.botoes_encoded != '0) && (bus.botoes_encoded != nota_reg)) begin
                  nota_reg <= bus.botoes_encoded;
                  ticks    <= '0;
                  estado   <= MEDINDO;
               end else begin
                  estado <= ESPERA;
               end
            end
            MARCA: begin
               bus.pronto  <= 1'b1;
               bus.ocupado <= 1'b0;
               para_visto  <= 1'b0;
               estado      <= FIM;
            end
            FIM: begin
               estado <= OCIOSO;
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gravador_musica.sv
// Drives key/metro/para sequences and checks the written words against a note-level model.
module tb_gravador_musica;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   gravador_musica_if #(.ADDR_W(5), .NOTA_W(4), .TEMPO_W(4)) bus ();

   gravador_musica #(.ADDR_W(5), .NOTA_W(4), .TEMPO_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int addr;
      int nota;
      int tempo;
      int ciclo;
   } escrita_t;

   escrita_t escritas[$];
   int       esp_nota[$];
   int       esp_tempo[$];
   int       ciclo_n = 0;
   int       n_pronto = 0;
   int       pronto_ciclo = 0;
   int       ocupado_no_pronto = 0;
   int       testes = 0;
   int       falhas = 0;

   always @(posedge clock) ciclo_n++;

   always @(negedge clock) begin
      if (reset && bus.we === 1'b1)
         escritas.push_back('{int'(bus.addr), int'(bus.data_nota), int'(bus.data_tempo), ciclo_n});
      if (reset && bus.pronto === 1'b1) begin
         n_pronto++;
         pronto_ciclo = ciclo_n;
         ocupado_no_pronto = int'(bus.ocupado);
      end
   end

   task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      testes++;
      if (obs !== esp) begin
         falhas++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   task automatic pulso_para();
      bus.para = 1'b1;
      ciclo();
      bus.para = 1'b0;
   endtask

   task automatic inicia_gravacao();
      ciclo();
      escritas.delete();
      esp_nota.delete();
      esp_tempo.delete();
      n_pronto = 0;
      bus.inicia = 1'b1;
      ciclo();
      bus.inicia = 1'b0;
      confere("ocupado_inicio", bus.ocupado, 1);
      confere("cheia_inicio", bus.cheia, 0);
   endtask

   // Hold key k for n metro pulses, then move to prox (0 = release) or stop with para.
   task automatic segura(input int k, input int n, input int prox, input bit coincide, input bit com_para);
      esp_nota.push_back(k);
      esp_tempo.push_back(n == 0 ? 1 : (n > 15 ? 15 : n));
      bus.botoes_encoded = 4'(k);
      ciclo();
      ciclo();
      for (int i = 0; i < n; i++) begin
         bus.metro = 1'b1;
         if (i == n - 1 && coincide && !com_para) bus.botoes_encoded = 4'(prox);
         ciclo();
         bus.metro = 1'b0;
         if (i != n - 1) repeat ($urandom_range(0, 2)) ciclo();
      end
      if (com_para) begin
         pulso_para();
         ciclo();
         bus.botoes_encoded = '0;
      end else begin
         if (!(coincide && n > 0)) begin
            bus.botoes_encoded = 4'(prox);
            ciclo();
         end
         ciclo();
      end
   endtask

   task automatic termina(input int cheia_esp);
      int espera = 0;
      while (n_pronto == 0 && espera < 60) begin
         ciclo();
         espera++;
      end
      confere("pronto_visto", n_pronto, 1);
      confere("n_escritas", escritas.size(), esp_nota.size() + 1);
      for (int i = 0; i < esp_nota.size() && i < escritas.size(); i++) begin
         confere("addr", escritas[i].addr, i);
         confere("nota", escritas[i].nota, esp_nota[i]);
         confere("tempo", escritas[i].tempo, esp_tempo[i]);
      end
      if (escritas.size() > 0) begin
         confere("marca_addr", escritas[$].addr, esp_nota.size());
         confere("marca_nota", escritas[$].nota, 0);
         confere("marca_tempo", escritas[$].tempo, 0);
         confere("pronto_lat", pronto_ciclo - escritas[$].ciclo, 1);
      end
      confere("ocupado_no_pronto", ocupado_no_pronto, 0);
      confere("cheia", bus.cheia, cheia_esp);
      ciclo();
      confere("ocupado_fim", bus.ocupado, 0);
   endtask

   function automatic int outra_tecla(input int k);
      int t;
      do t = int'($urandom_range(1, 15)); while (t == k);
      return t;
   endfunction

   task automatic grava_aleatorio();
      int nn, k, n, prox;
      bit ultimo, parado;
      inicia_gravacao();
      nn = int'($urandom_range(1, 6));
      k = int'($urandom_range(1, 15));
      parado = 1'b0;
      for (int i = 0; i < nn; i++) begin
         n = int'($urandom_range(0, 18));
         ultimo = (i == nn - 1);
         parado = ultimo && ($urandom_range(0, 1) == 1);
         prox = ultimo ? 0 : (($urandom_range(0, 1) == 1) ? 0 : outra_tecla(k));
         segura(k, n, prox, (n > 0) && ($urandom_range(0, 1) == 1), parado);
         k = (prox != 0) ? prox : int'($urandom_range(1, 15));
      end
      if (!parado) pulso_para();
      termina(0);
   endtask

   initial begin
      bus.inicia = 1'b0;
      bus.para = 1'b0;
      bus.metro = 1'b0;
      bus.botoes_encoded = '0;
      #2 reset = 1'b0;
      #1;
      confere("rst_we", bus.we, 0);
      confere("rst_addr", bus.addr, 0);
      confere("rst_ocupado", bus.ocupado, 0);
      confere("rst_pronto", bus.pronto, 0);
      confere("rst_cheia", bus.cheia, 0);
      confere("rst_estado", bus.db_estado, 0);
      repeat (2) ciclo();
      reset = 1'b1;

      // Two notes with a stray inicia between them that must not restart addr.
      inicia_gravacao();
      segura(3, 4, 0, 0, 0);
      bus.inicia = 1'b1;
      ciclo();
      bus.inicia = 1'b0;
      segura(7, 2, 0, 0, 0);
      pulso_para();
      termina(0);

      inicia_gravacao();
      segura(5, 0, 0, 0, 0);
      pulso_para();
      termina(0);

      inicia_gravacao();
      segura(2, 20, 0, 0, 0);
      pulso_para();
      termina(0);

      inicia_gravacao();
      segura(4, 2, 9, 1, 0);
      segura(9, 3, 0, 0, 0);
      pulso_para();
      termina(0);

      inicia_gravacao();
      segura(6, 3, 0, 0, 1);
      termina(0);

      repeat (6) grava_aleatorio();

      // Fill the memory; the recorder must close it on its own.
      inicia_gravacao();
      for (int i = 0; i < 31; i++)
         segura(int'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
      termina(1);
      bus.botoes_encoded = 4'd5;
      repeat (4) ciclo();
      bus.botoes_encoded = '0;
      repeat (4) ciclo();
      confere("press_ignorada", escritas.size(), 32);

      // Asynchronous abort mid-note.
      inicia_gravacao();
      segura(8, 2, 0, 0, 0);
      bus.botoes_encoded = 4'd1;
      repeat (3) ciclo();
      #2 reset = 1'b0;
      #1;
      confere("abort_we", bus.we, 0);
      confere("abort_addr", bus.addr, 0);
      confere("abort_nota", bus.data_nota, 0);
      confere("abort_tempo", bus.data_tempo, 0);
      confere("abort_ocupado", bus.ocupado, 0);
      confere("abort_pronto", bus.pronto, 0);
      confere("abort_cheia", bus.cheia, 0);
      confere("abort_estado", bus.db_estado, 0);
      bus.botoes_encoded = '0;
      repeat (2) ciclo();
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end
endmodule

// File: doc/gravador_musica.md
# gravador_musica

Records a song played on the piano keys into the 32x4 note/tempo song RAM, the write side of the memory the playback and game datapath reads. Each key press becomes one word: the pressed note code plus its held duration in metronome ticks. On stop, or when the memory fills, the block writes an end-of-song marker so the reader's end-of-song detection fires at the right address.

## Interface
Parameters:
- ADDR_W, 5, address width; memory depth is 2^ADDR_W words, and the last word is reserved for the end marker.
- NOTA_W, 4, width of the note code; code 0 means no key pressed.
- TEMPO_W, 4, width of the duration field in metronome ticks; the counter saturates at 2^TEMPO_W-1.

Ports:
- clock  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- inicia  in  1  one-cycle pulse; starts a recording at address 0.
- para  in  1  one-cycle pulse; ends the recording.
- botoes_encoded  in  NOTA_W  synchronous, debounced key code; 0 means no key.
- metro  in  1  one-cycle pulse per metronome tick.
- we  out  1  RAM write enable.
- addr  out  ADDR_W  RAM address.
- data_nota  out  NOTA_W  note written.
- data_tempo  out  TEMPO_W  duration written.
- ocupado  out  1  high from the cycle after inicia is accepted until pronto.
- pronto  out  1  one-cycle pulse after the end marker is written.
- cheia  out  1  high when recording stopped because memory was full; cleared by the next accepted inicia.
- db_estado  out  3  current FSM state encoding, for debug.

## Operation
- Reset value of every output is 0. The FSM resets to OCIOSO and the internal tick counter to 0.
- FSM states and transitions:
  - OCIOSO: on inicia, clear addr and cheia, go to ESPERA. para is ignored.
  - ESPERA: on botoes_encoded≠0, latch the code into nota_reg, clear the tick counter, go to MEDINDO. On para, go to MARCA.
  - MEDINDO: each metro pulse increments the tick counter, saturating at 2^TEMPO_W-1. Go to GRAVA on any of:
    - botoes_encoded==0 (release);
    - botoes_encoded≠nota_reg and ≠0 (note change);
    - para.
  - GRAVA: for one cycle, we=1, data_nota=nota_reg, data_tempo=max(ticks,1), at the current addr. Then addr increments. Next state is chosen in this priority order:
    1. If the written addr was 2^ADDR_W-2: set cheia, go to MARCA.
    2. Else if para was seen during MEDINDO (latched flag): go to MARCA.
    3. Else if the key code is nonzero and differs from the note just written: latch it, clear ticks, go to MEDINDO.
    4. Else go to ESPERA.
  - MARCA: for one cycle, we=1, data_nota=0, data_tempo=0, at the current addr. Go to FIM.
  - FIM: pronto=1 for one cycle, ocupado drops, go to OCIOSO.
- inicia is ignored in every state except OCIOSO.
- While a key is held past a note-change boundary, each distinct code becomes its own word.
- A metro pulse in the same cycle that the release is sampled is counted.
- A para arriving during GRAVA is latched and takes effect when GRAVA exits.
- addr never wraps. At most 2^ADDR_W-1 notes are stored, plus 1 marker word.
- Reset asserted mid-recording aborts immediately. Partially written RAM contents are not repaired.

## Timing
- All outputs are registered.
- If a release is sampled at edge k, we=1 in the cycle following edge k, and addr has advanced by edge k+2.
- Write latency from key release to we is 1 cycle; from para in ESPERA to marker we is 1 cycle.
- pronto follows the marker write by exactly 1 cycle.
- A recording of n notes with no pending note at stop takes n+2 write/ack cycles after the last release.
- data_nota and data_tempo are valid only while we=1; they hold their last value otherwise.

## Test plan
- inicia; key 3 held for 4 metro pulses then released; key 7 held for 2 pulses; para → writes (0,3,4), (1,7,2), marker (2,0,0); pronto 1 cycle later; cheia=0.
- Key 5 pressed and released with no metro pulse → word data_tempo=1.
- Key 2 held for 20 pulses → data_tempo=15 (saturated).
- Key 4 changes directly to key 9 without a release → two words (4,t1), (9,t2) with no gap state between them.
- para while key 6 is held for 3 pulses → writes (0,6,3) then marker at addr 1.
- 31 presses → words at addr 0..30, cheia=1, marker at addr 31, pronto. A 32nd press is ignored. reset low mid-recording → all outputs 0 and db_estado equal to OCIOSO asynchronously.
